fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 131 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard for an in-order pipeline.
// Tracks the destination register of the last DEPTH instructions that left
// ID, picks a forwarding source per ID operand, and requests a stall when the
// youngest producer of an operand has not yet reached its forwardable stage.
module fwd_scoreboard #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int CNT_W = 16,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic [2:0]       id_ready_stage,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic [FW-1:0]    forward_rs1,
  output logic [FW-1:0]    forward_rs2,
  output logic [FW-1:0]    inflight,
  output logic [CNT_W-1:0] stall_cycles
);

  // Entry k holds the instruction that left ID k advances ago.
  logic [DEPTH:1]   ent_valid;
  logic [REG_W-1:0] ent_rd  [1:DEPTH];
  logic [2:0]       ent_rdy [1:DEPTH];
  logic [CNT_W-1:0] stall_cnt;

  logic [2:0]       rdy_clamped;
  logic             accept;

  // Per-operand views so both sources share one resolution datapath.
  logic [REG_W-1:0] src_rs  [2];
  logic [1:0]       src_use;
  logic [1:0]       src_req;
  logic [FW-1:0]    src_fwd [2];

  assign src_rs[0]  = id_rs1;
  assign src_rs[1]  = id_rs2;
  assign src_use[0] = id_use_rs1;
  assign src_use[1] = id_use_rs2;

  // Ready stage 0 means "as early as possible"; anything beyond the last
  // tracked entry is forwardable only from the last one.
  always_comb begin
    rdy_clamped = id_ready_stage;
    if (id_ready_stage == 3'd0) begin
      rdy_clamped = 3'd1;
    end else if (id_ready_stage > 3'(DEPTH)) begin
      rdy_clamped = 3'(DEPTH);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic          hit;
      logic          hit_ready;
      logic [FW-1:0] hit_k;

      // Walk oldest to youngest so the youngest matching producer wins; its
      // readiness alone decides forward vs stall, older copies are ignored.
      always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_k     = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (ent_valid[k] && (ent_rd[k] == src_rs[gi]) && src_use[gi] &&
              (src_rs[gi] != '0) && id_valid) begin
            hit       = 1'b1;
            hit_k     = FW'(k);
            hit_ready = (3'(k) >= ent_rdy[k]);
          end
        end
      end

      assign src_req[gi] = hit && !hit_ready;
      assign src_fwd[gi] = (hit && hit_ready) ? hit_k : '0;
    end
  endgenerate

  assign stall       = id_valid && !flush && (|src_req);
  assign forward_rs1 = stall ? '0 : src_fwd[0];
  assign forward_rs2 = stall ? '0 : src_fwd[1];

  // Only real, non-squashed, non-stalled writers to a non-zero register
  // become producers; everything else enters as a bubble.
  assign accept = id_valid && id_reg_write && (id_rd != '0) && !stall && !flush;

  // Advance the entry shift register and stall counter unless frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        ent_rd[k]  <= '0;
        ent_rdy[k] <= '0;
      end
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_rd[k]    <= ent_rd[k-1];
        ent_rdy[k]   <= ent_rdy[k-1];
      end
      ent_valid[1] <= accept;
      ent_rd[1]    <= id_rd;
      ent_rdy[1]   <= rdy_clamped;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // Population count of the registered valid bits.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      inflight = inflight + FW'(ent_valid[k]);
    end
  end

  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard (DEPTH=3). A second instance with a
// 2-bit stall counter shares the stimulus to exercise counter saturation.
module tb_fwd_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write;
  logic [2:0] id_ready_stage;
  logic       flush, hold;

  logic        stall_a;
  logic [1:0]  f1_a, f2_a, infl_a;
  logic [15:0] cnt_a;
  logic        stall_b;
  logic [1:0]  f1_b, f2_b, infl_b;
  logic [1:0]  cnt_b;

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [1:0]  infl;
    logic [15:0] cnt;
    logic [1:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  fwd_scoreboard dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_ready_stage(id_ready_stage),
    .flush(flush), .hold(hold),
    .stall(stall_a), .forward_rs1(f1_a), .forward_rs2(f2_a),
    .inflight(infl_a), .stall_cycles(cnt_a)
  );

  fwd_scoreboard #(.DEPTH(3), .REG_W(5), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_ready_stage(id_ready_stage),
    .flush(flush), .hold(hold),
    .stall(stall_b), .forward_rs1(f1_b), .forward_rs2(f2_b),
    .inflight(infl_b), .stall_cycles(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every queued expectation is
  // compared at the falling edge of the cycle it was issued in.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (stall_a !== e.stall || f1_a !== e.f1 || f2_a !== e.f2 ||
          infl_a !== e.infl || cnt_a !== e.cnt ||
          stall_b !== e.stall || cnt_b !== e.cnt_b) begin
        miscompares++;
        $display("FAIL %s: got stall=%0b fwd1=%0d fwd2=%0d inflight=%0d cnt=%0d stall_b=%0b cnt_b=%0d; want stall=%0b fwd1=%0d fwd2=%0d inflight=%0d cnt=%0d cnt_b=%0d",
                 e.name, stall_a, f1_a, f2_a, infl_a, cnt_a, stall_b, cnt_b,
                 e.stall, e.f1, e.f2, e.infl, e.cnt, e.cnt_b);
      end else begin
        $display("vec %s: stall=%0b fwd1=%0d fwd2=%0d inflight=%0d cnt=%0d cnt_b=%0d ok",
                 e.name, stall_a, f1_a, f2_a, infl_a, cnt_a, cnt_b);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic w, input logic [2:0] rs,
                       input logic fl, input logic hd);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = w; id_ready_stage = rs; flush = fl; hold = hd;
  endtask

  // Push the expected response; the 2-bit counter copy saturates at 3.
  task automatic expect_out(input string nm, input logic st, input int f1,
                            input int f2, input int infl, input int cnt);
    exp_t e;
    e.name  = nm;
    e.stall = st;
    e.f1    = 2'(f1);
    e.f2    = 2'(f2);
    e.infl  = 2'(infl);
    e.cnt   = 16'(cnt);
    e.cnt_b = (cnt > 3) ? 2'd3 : 2'(cnt);
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    expect_out("reset_state", 0, 0, 0, 0, 0);

    // ALU x5, then read it back through each forwarding stage.
    next_cycle(); reset = 1'b1;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); expect_out("alu_x5_issue", 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); expect_out("alu_fwd_e1", 0, 1, 0, 1, 0);
    next_cycle(); expect_out("alu_fwd_e2", 0, 2, 0, 1, 0);
    next_cycle(); expect_out("alu_fwd_e3", 0, 3, 0, 1, 0);
    next_cycle(); expect_out("alu_fwd_rf", 0, 0, 0, 0, 0);

    // Load-use: one stall, then forward from entry 2.
    next_cycle(); drive(1, 0, 0, 0, 0, 6, 1, 2, 0, 0); expect_out("load_x6_issue", 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 0); expect_out("load_use_stall", 1, 0, 0, 1, 0);
    next_cycle(); expect_out("load_use_fwd2", 0, 0, 2, 1, 1);

    // Two writers of x7: youngest wins; x0 never forwards.
    next_cycle(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); expect_out("alu_x7_a", 0, 0, 0, 1, 1);
    next_cycle(); expect_out("alu_x7_b", 0, 0, 0, 1, 1);
    next_cycle(); drive(1, 7, 1, 7, 1, 0, 1, 1, 0, 0); expect_out("youngest_wins", 0, 1, 1, 2, 1);
    next_cycle(); drive(1, 0, 1, 7, 1, 0, 0, 0, 0, 0); expect_out("x0_no_fwd", 0, 0, 2, 2, 1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("idle", 0, 0, 0, 1, 1);

    // Load x8 with the pipeline held for 4 cycles.
    next_cycle(); drive(1, 0, 0, 0, 0, 8, 1, 2, 0, 0); expect_out("load_x8_issue", 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 1); expect_out("hold_stall", 1, 0, 0, 1, 1);
    end
    next_cycle(); drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0); expect_out("hold_release", 1, 0, 0, 1, 1);
    next_cycle(); expect_out("hold_fwd2", 0, 2, 0, 1, 2);

    // Flush squashes both the stall and the ID write.
    next_cycle(); drive(1, 0, 0, 0, 0, 9, 1, 2, 0, 0); expect_out("load_x9_issue", 0, 0, 0, 1, 2);
    next_cycle(); drive(1, 9, 1, 0, 0, 10, 1, 1, 1, 0); expect_out("flush_no_stall", 0, 0, 0, 1, 2);
    next_cycle(); drive(1, 10, 1, 9, 1, 0, 0, 0, 0, 0); expect_out("flush_bubble", 0, 0, 2, 1, 2);

    // Fill all three entries, then assert reset without a clock edge.
    next_cycle(); drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); expect_out("fill_x1", 0, 0, 0, 1, 2);
    next_cycle(); drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); expect_out("fill_x2", 0, 0, 0, 1, 2);
    next_cycle(); drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); expect_out("fill_x3", 0, 0, 0, 2, 2);
    next_cycle(); drive(1, 1, 1, 2, 1, 4, 1, 1, 0, 0); expect_out("three_valid", 0, 3, 2, 3, 2);
    next_cycle(); reset = 1'b0; drive(1, 4, 1, 3, 1, 0, 0, 0, 0, 0);
    expect_out("async_reset", 0, 0, 0, 0, 0);
    next_cycle(); reset = 1'b1; expect_out("post_reset_empty", 0, 0, 0, 0, 0);

    // Ready-stage clamping: 0 acts as 1, 7 acts as 3.
    next_cycle(); drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0); expect_out("rdy0_issue", 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 11, 1, 0, 0, 12, 1, 7, 0, 0); expect_out("rdy0_fwd1", 0, 1, 0, 1, 0);
    next_cycle(); drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0); expect_out("rdy7_stall_e1", 1, 0, 0, 2, 0);
    next_cycle(); expect_out("rdy7_stall_e2", 1, 0, 0, 2, 1);
    next_cycle(); expect_out("rdy7_fwd3", 0, 3, 0, 1, 2);

    // Youngest not ready, older ready: must stall, not forward the older.
    next_cycle(); drive(1, 0, 0, 0, 0, 13, 1, 1, 0, 0); expect_out("alu_x13", 0, 0, 0, 0, 2);
    next_cycle(); drive(1, 0, 0, 0, 0, 13, 1, 2, 0, 0); expect_out("load_x13", 0, 0, 0, 1, 2);
    next_cycle(); drive(1, 13, 1, 0, 0, 0, 0, 0, 0, 0); expect_out("no_older_fwd", 1, 0, 0, 2, 2);

    // More stalls to push the 2-bit counter into saturation.
    next_cycle(); drive(1, 0, 0, 0, 0, 14, 1, 3, 0, 0); expect_out("load_x14", 0, 0, 0, 2, 3);
    next_cycle(); drive(1, 14, 1, 0, 0, 0, 0, 0, 0, 0); expect_out("sat_stall_a", 1, 0, 0, 2, 3);
    next_cycle(); expect_out("sat_stall_b", 1, 0, 0, 1, 4);
    next_cycle(); expect_out("sat_final", 0, 3, 0, 1, 5);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
